// File: rtl/ccff_loader_pkg.sv
// Shared types and sizing helpers for the configuration-chain loader.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package ccff_loader_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_WORD = 2'd1,
      SHIFT     = 2'd2,
      DONE      = 2'd3
   } state_t;

   // Width of a counter that must reach chain_len inclusive.
   function automatic int cnt_w_of(input int chain_len);
      return $clog2(chain_len + 1);
   endfunction

   // Width of a bit index within one word.
   function automatic int bit_w_of(input int word_w);
      return $clog2(word_w);
   endfunction

   // Number of bits actually shifted out of the final bitstream word.
   function automatic int last_word_bits(input int chain_len, input int word_w);
      int rem;
      rem = chain_len % word_w;
      return (rem == 0) ? word_w : rem;
   endfunction

endpackage

// File: rtl/ccff_rb_packer.sv
// Serial-to-parallel packer: collects chain tail bits into MSB-first readback words.
// Latency: rb_valid/rb_data appear the cycle after the sample that completes a word or flushes.
// Backpressure: none; every completed word is presented for exactly one cycle.
module ccff_rb_packer
   import ccff_loader_pkg::*;
#(
   parameter int WORD_W = 32
) (
   input  logic              prog_clk,
   input  logic              prog_reset,
   input  logic              sample,
   input  logic              sample_bit,
   input  logic              flush,
   input  logic              clear,
   output logic              rb_valid,
   output logic [WORD_W-1:0] rb_data
);

   localparam int BIT_W = bit_w_of(WORD_W);
   localparam logic [BIT_W-1:0] TOP_IDX = BIT_W'(WORD_W - 1);

   logic [WORD_W-1:0] acc;
   logic [WORD_W-1:0] acc_nxt;
   logic [BIT_W-1:0]  cnt;

   // Place the incoming bit at the next free position counting down from the MSB.
   always_comb begin
      acc_nxt = acc;
      acc_nxt[TOP_IDX - cnt] = sample_bit;
   end

   // Accumulate samples; emit on a full word or on flush, and drop partial data on clear.
   always_ff @(posedge prog_clk or negedge prog_reset) begin
      if (!prog_reset) begin
         acc      <= '0;
         cnt      <= '0;
         rb_valid <= 1'b0;
         rb_data  <= '0;
      end else if (clear) begin
         acc      <= '0;
         cnt      <= '0;
         rb_valid <= 1'b0;
      end else begin
         rb_valid <= 1'b0;
         if (sample) begin
            if ((cnt == TOP_IDX) || flush) begin
               rb_valid <= 1'b1;
               rb_data  <= acc_nxt;
               acc      <= '0;
               cnt      <= '0;
            end else begin
               acc <= acc_nxt;
               cnt <= cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/ccff_chain_loader.sv
// Loads bitstream words MSB-first onto a config chain head and packs the old tail content for readback.
// Latency: first bit on ccff_head (ccff_clk_en=1) one cycle after the word handshake; done one cycle after last bit.
// Backpressure: s_ready only in WAIT_WORD or on the last bit of a word; readback has no backpressure.
module ccff_chain_loader
   import ccff_loader_pkg::*;
#(
   parameter int CHAIN_LEN = 128,
   parameter int WORD_W    = 32
) (
   input  logic              prog_clk,
   input  logic              prog_reset,
   input  logic              start,
   input  logic              abort,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [WORD_W-1:0] s_data,
   output logic              ccff_head,
   output logic              ccff_clk_en,
   input  logic              ccff_tail,
   output logic              rb_valid,
   output logic [WORD_W-1:0] rb_data,
   output logic              busy,
   output logic              done
);

   localparam int CNT_W     = cnt_w_of(CHAIN_LEN);
   localparam int BIT_W     = bit_w_of(WORD_W);
   localparam int LAST_BITS = last_word_bits(CHAIN_LEN, WORD_W);

   localparam logic [CNT_W-1:0] CHAIN_END = CNT_W'(CHAIN_LEN);
   localparam logic [BIT_W-1:0] FULL_LEFT = BIT_W'(WORD_W - 1);
   localparam logic [BIT_W-1:0] LAST_LEFT = BIT_W'(LAST_BITS - 1);

   state_t            state;
   state_t            state_nxt;
   logic [WORD_W-1:0] sreg;
   logic [CNT_W-1:0]  bit_cnt;
   logic [BIT_W-1:0]  word_left;
   logic [CNT_W-1:0]  bits_rem;

   logic chain_full;
   logic word_empty;
   logic last_word;
   logic handshake;
   logic take_word;
   logic shift_next;
   logic go_quiet;

   // bit_cnt counts bits already launched onto ccff_head; word_left counts bits still in sreg.
   assign chain_full = (bit_cnt == CHAIN_END);
   assign word_empty = (word_left == '0);
   assign bits_rem   = CHAIN_END - bit_cnt;
   assign last_word  = (int'(bits_rem) <= WORD_W);
   assign handshake  = s_valid & s_ready;
   // abort takes priority: a word handshaken in the abort cycle is discarded.
   assign take_word  = handshake & ~abort;
   assign shift_next = (state == SHIFT) & ~abort & ~chain_full & ~word_empty;
   assign go_quiet   = (state_nxt == IDLE) || (state_nxt == DONE);

   // State register.
   always_ff @(posedge prog_clk or negedge prog_reset) begin
      if (!prog_reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and handshake/status decode.
   always_comb begin
      state_nxt = state;
      s_ready   = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nxt = WAIT_WORD;
         end
         WAIT_WORD: begin
            busy    = 1'b1;
            s_ready = 1'b1;
            if (abort)        state_nxt = IDLE;
            else if (s_valid) state_nxt = SHIFT;
         end
         SHIFT: begin
            busy    = 1'b1;
            // Accept the next word while its predecessor's last bit is on the head.
            s_ready = word_empty & ~chain_full;
            if (abort)                       state_nxt = IDLE;
            else if (chain_full)             state_nxt = DONE;
            else if (!word_empty || s_valid) state_nxt = SHIFT;
            else                             state_nxt = WAIT_WORD;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Shift datapath: launch one bit per cycle from a new word or the held word; clear when leaving the run.
   always_ff @(posedge prog_clk or negedge prog_reset) begin
      if (!prog_reset) begin
         ccff_head   <= 1'b0;
         ccff_clk_en <= 1'b0;
         sreg        <= '0;
         bit_cnt     <= '0;
         word_left   <= '0;
      end else begin
         ccff_clk_en <= take_word | shift_next;
         if (take_word) begin
            ccff_head <= s_data[WORD_W-1];
            sreg      <= {s_data[WORD_W-2:0], 1'b0};
            word_left <= last_word ? LAST_LEFT : FULL_LEFT;
            bit_cnt   <= bit_cnt + 1'b1;
         end else if (shift_next) begin
            ccff_head <= sreg[WORD_W-1];
            sreg      <= {sreg[WORD_W-2:0], 1'b0};
            word_left <= word_left - 1'b1;
            bit_cnt   <= bit_cnt + 1'b1;
         end else if (go_quiet) begin
            // In WAIT_WORD the head is left holding its last bit.
            ccff_head <= 1'b0;
            sreg      <= '0;
            bit_cnt   <= '0;
            word_left <= '0;
         end
      end
   end

   // Tail sampling follows the chain clock enable; the final bit flushes a partial word.
   ccff_rb_packer #(
      .WORD_W(WORD_W)
   ) u_rb_packer (
      .prog_clk   (prog_clk),
      .prog_reset (prog_reset),
      .sample     (ccff_clk_en),
      .sample_bit (ccff_tail),
      .flush      (ccff_clk_en & chain_full),
      .clear      (abort & busy),
      .rb_valid   (rb_valid),
      .rb_data    (rb_data)
   );

endmodule

// File: tb/tb_ccff_chain_loader.sv
module tb_ccff_chain_loader;

   logic       prog_clk;
   logic       prog_reset;
   logic [2:0] start;
   logic [2:0] abort;
   logic [2:0] s_valid;
   logic [2:0] s_ready;
   logic [7:0] s_data [3];
   logic [2:0] head;
   logic [2:0] clk_en;
   logic [2:0] tail;
   logic [2:0] rb_valid;
   logic [7:0] rb_data [3];
   logic [2:0] busy;
   logic [2:0] done;

   // Behavioural chains: shift in at bit 0 on enabled edges, tail is the top bit of each chain length.
   logic [31:0] chain   [3];
   logic [2:0]  pre_req;
   logic [31:0] pre_val [3];

   int checks;
   int failures;

   int en_cnt   [3];
   int acc_cnt  [3];
   int done_cnt [3];
   int rbv_cnt  [3];
   int bubble   [3];
   int viol     [3];
   logic [31:0] stream [3];
   logic [2:0]  seen_en;
   logic [2:0]  last_head;
   logic [7:0]  rb_log [3][4];

   ccff_chain_loader #(.CHAIN_LEN(8), .WORD_W(8)) u_dut8 (
      .prog_clk(prog_clk), .prog_reset(prog_reset), .start(start[0]), .abort(abort[0]),
      .s_valid(s_valid[0]), .s_ready(s_ready[0]), .s_data(s_data[0]),
      .ccff_head(head[0]), .ccff_clk_en(clk_en[0]), .ccff_tail(tail[0]),
      .rb_valid(rb_valid[0]), .rb_data(rb_data[0]), .busy(busy[0]), .done(done[0]));

   ccff_chain_loader #(.CHAIN_LEN(16), .WORD_W(8)) u_dut16 (
      .prog_clk(prog_clk), .prog_reset(prog_reset), .start(start[1]), .abort(abort[1]),
      .s_valid(s_valid[1]), .s_ready(s_ready[1]), .s_data(s_data[1]),
      .ccff_head(head[1]), .ccff_clk_en(clk_en[1]), .ccff_tail(tail[1]),
      .rb_valid(rb_valid[1]), .rb_data(rb_data[1]), .busy(busy[1]), .done(done[1]));

   ccff_chain_loader #(.CHAIN_LEN(20), .WORD_W(8)) u_dut20 (
      .prog_clk(prog_clk), .prog_reset(prog_reset), .start(start[2]), .abort(abort[2]),
      .s_valid(s_valid[2]), .s_ready(s_ready[2]), .s_data(s_data[2]),
      .ccff_head(head[2]), .ccff_clk_en(clk_en[2]), .ccff_tail(tail[2]),
      .rb_valid(rb_valid[2]), .rb_data(rb_data[2]), .busy(busy[2]), .done(done[2]));

   assign tail[0] = chain[0][7];
   assign tail[1] = chain[1][15];
   assign tail[2] = chain[2][19];

   initial prog_clk = 1'b0;
   always #5 prog_clk = ~prog_clk;

   always @(posedge prog_clk) begin
      for (int d = 0; d < 3; d++) begin
         if (pre_req[d])     chain[d] <= pre_val[d];
         else if (clk_en[d]) chain[d] <= {chain[d][30:0], head[d]};
      end
   end

   // Per-cycle monitor, sampled mid-low-phase after inputs have settled.
   always begin
      @(negedge prog_clk);
      #2;
      for (int d = 0; d < 3; d++) begin
         if (clk_en[d]) begin
            en_cnt[d]++;
            stream[d]    = {stream[d][30:0], head[d]};
            last_head[d] = head[d];
            seen_en[d]   = 1'b1;
         end else if (busy[d] && seen_en[d]) begin
            bubble[d]++;
            if (head[d] !== last_head[d]) viol[d]++;
         end
         if (s_valid[d] && s_ready[d]) acc_cnt[d]++;
         if (done[d]) done_cnt[d]++;
         if (rb_valid[d]) begin
            if (rbv_cnt[d] < 4) rb_log[d][rbv_cnt[d]] = rb_data[d];
            rbv_cnt[d]++;
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%b required=%b", nm, act, exp);
      end
   endtask

   task automatic clear_mon(input int d);
      en_cnt[d] = 0; acc_cnt[d] = 0; done_cnt[d] = 0; rbv_cnt[d] = 0;
      bubble[d] = 0; viol[d] = 0; stream[d] = '0; seen_en[d] = 1'b0;
      for (int k = 0; k < 4; k++) rb_log[d][k] = 8'h00;
   endtask

   task automatic preload(input int d, input logic [31:0] v);
      @(negedge prog_clk);
      pre_val[d] = v;
      pre_req[d] = 1'b1;
      @(negedge prog_clk);
      pre_req[d] = 1'b0;
   endtask

   task automatic pulse_start(input int d);
      @(negedge prog_clk);
      start[d] = 1'b1;
      @(negedge prog_clk);
      start[d] = 1'b0;
   endtask

   // Waits for gap cycles of s_ready before offering the word, then holds it until accepted.
   task automatic feed_word(input int d, input logic [7:0] w, input int gap);
      int seen;
      int guard;
      seen  = 0;
      guard = 0;
      while (seen < gap && guard < 200) begin
         #1;
         if (s_ready[d]) seen++;
         @(negedge prog_clk);
         guard++;
      end
      s_valid[d] = 1'b1;
      s_data[d]  = w;
      #1;
      while (!s_ready[d] && guard < 200) begin
         @(negedge prog_clk);
         #1;
         guard++;
      end
      chk1($sformatf("feed_accept_d%0d", d), guard < 200, 1'b1);
      @(negedge prog_clk);
      s_valid[d] = 1'b0;
   endtask

   task automatic wait_done(input int d, input int budget);
      int d0;
      int n;
      d0 = done_cnt[d];
      n  = 0;
      while (done_cnt[d] == d0 && n < budget) begin
         @(negedge prog_clk);
         #3;
         n++;
      end
      chk1($sformatf("done_seen_d%0d", d), n < budget, 1'b1);
      @(negedge prog_clk);
   endtask

   typedef struct {
      logic       start;
      logic       abort;
      logic       s_valid;
      logic [7:0] s_data;
      logic       e_rdy;
      logic       e_head;
      logic       e_en;
      logic       e_busy;
      logic       e_done;
      logic       e_rbv;
      logic [7:0] e_rbd;
   } vec_t;

   vec_t vt [17];
   int   d0_done;
   int   d0_rbv;

   initial begin
      // Cycle-by-cycle vectors for the 8-bit chain: load 8'hA5 over a chain preloaded with 8'h3C,
      // then start/abort interplay in IDLE and WAIT_WORD.
      //         start abort valid data     rdy   head  en    busy  done  rbv   rbd
      vt[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
      vt[1]  = '{1'b0, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
      vt[2]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
      vt[3]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
      vt[4]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
      vt[5]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
      vt[6]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
      vt[7]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
      vt[8]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
      vt[9]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
      vt[10] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h3C};
      vt[11] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
      vt[12] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
      vt[13] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
      vt[14] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
      vt[15] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
      vt[16] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};

      checks   = 0;
      failures = 0;
      start    = '0;
      abort    = '0;
      s_valid  = '0;
      pre_req  = '0;
      last_head = '0;
      for (int d = 0; d < 3; d++) begin
         s_data[d]  = 8'h00;
         pre_val[d] = '0;
         chain[d]   = '0;
         clear_mon(d);
      end

      // Reset state of every instance.
      prog_reset = 1'b0;
      #12;
      for (int d = 0; d < 3; d++) begin
         chk1($sformatf("rst_s_ready_d%0d", d), s_ready[d], 1'b0);
         chk1($sformatf("rst_head_d%0d", d), head[d], 1'b0);
         chk1($sformatf("rst_clk_en_d%0d", d), clk_en[d], 1'b0);
         chk1($sformatf("rst_rb_valid_d%0d", d), rb_valid[d], 1'b0);
         chk1($sformatf("rst_busy_d%0d", d), busy[d], 1'b0);
         chk1($sformatf("rst_done_d%0d", d), done[d], 1'b0);
         chk($sformatf("rst_rb_data_d%0d", d), {24'h0, rb_data[d]}, 32'h0);
      end
      @(negedge prog_clk);
      prog_reset = 1'b1;

      // Table-driven run on the 8-bit chain.
      preload(0, 32'h3C);
      for (int i = 0; i < 17; i++) begin
         @(negedge prog_clk);
         start[0]   = vt[i].start;
         abort[0]   = vt[i].abort;
         s_valid[0] = vt[i].s_valid;
         s_data[0]  = vt[i].s_data;
         #1;
         chk1($sformatf("vec%0d_s_ready", i), s_ready[0], vt[i].e_rdy);
         chk1($sformatf("vec%0d_head", i), head[0], vt[i].e_head);
         chk1($sformatf("vec%0d_clk_en", i), clk_en[0], vt[i].e_en);
         chk1($sformatf("vec%0d_busy", i), busy[0], vt[i].e_busy);
         chk1($sformatf("vec%0d_done", i), done[0], vt[i].e_done);
         chk1($sformatf("vec%0d_rb_valid", i), rb_valid[0], vt[i].e_rbv);
         if (vt[i].e_rbv) chk($sformatf("vec%0d_rb_data", i), {24'h0, rb_data[0]}, {24'h0, vt[i].e_rbd});
      end
      start[0] = 1'b0;
      abort[0] = 1'b0;
      chk("d8_chain_after_load", chain[0] & 32'hFF, 32'hA5);

      // 16-bit chain preloaded 16'hBEEF, words 12,34 offered back-to-back.
      clear_mon(1);
      preload(1, 32'hBEEF);
      pulse_start(1);
      feed_word(1, 8'h12, 0);
      feed_word(1, 8'h34, 0);
      wait_done(1, 60);
      chk("b2b_en_cycles", en_cnt[1], 16);
      chk("b2b_bubbles", bubble[1], 0);
      chk("b2b_words", acc_cnt[1], 2);
      chk("b2b_stream", stream[1] & 32'hFFFF, 32'h1234);
      chk("b2b_rb_count", rbv_cnt[1], 2);
      chk("b2b_rb0", {24'h0, rb_log[1][0]}, 32'hBE);
      chk("b2b_rb1", {24'h0, rb_log[1][1]}, 32'hEF);
      chk("b2b_done_count", done_cnt[1], 1);
      chk("b2b_chain", chain[1] & 32'hFFFF, 32'h1234);

      // Second word held back 5 cycles: chain clock gated and head held meanwhile.
      clear_mon(1);
      pulse_start(1);
      feed_word(1, 8'hC3, 0);
      feed_word(1, 8'h5A, 5);
      wait_done(1, 60);
      chk("gap_en_cycles", en_cnt[1], 16);
      chk("gap_bubbles", bubble[1], 5);
      chk("gap_head_hold", viol[1], 0);
      chk("gap_stream", stream[1] & 32'hFFFF, 32'hC35A);
      chk("gap_rb0", {24'h0, rb_log[1][0]}, 32'h12);
      chk("gap_rb1", {24'h0, rb_log[1][1]}, 32'h34);
      chk("gap_chain", chain[1] & 32'hFFFF, 32'hC35A);

      // Abort after three bits have been clocked.
      clear_mon(1);
      pulse_start(1);
      feed_word(1, 8'hFF, 0);
      @(negedge prog_clk);
      @(negedge prog_clk);
      abort[1] = 1'b1;
      @(negedge prog_clk);
      abort[1] = 1'b0;
      #1;
      chk1("abort_clk_en", clk_en[1], 1'b0);
      chk1("abort_head", head[1], 1'b0);
      chk1("abort_busy", busy[1], 1'b0);
      chk1("abort_s_ready", s_ready[1], 1'b0);
      repeat (12) @(negedge prog_clk);
      chk("abort_en_cycles", en_cnt[1], 3);
      chk("abort_no_done", done_cnt[1], 0);
      chk("abort_no_rb", rbv_cnt[1], 0);
      chk("abort_chain", chain[1] & 32'hFFFF, 32'h1AD7);

      // 20-bit chain: partial final word, exactly three words taken even with a fourth offered.
      clear_mon(2);
      preload(2, 32'hABCDE);
      pulse_start(2);
      feed_word(2, 8'hFF, 0);
      feed_word(2, 8'h00, 0);
      feed_word(2, 8'hF0, 0);
      s_valid[2] = 1'b1;
      s_data[2]  = 8'h77;
      wait_done(2, 60);
      repeat (3) @(negedge prog_clk);
      s_valid[2] = 1'b0;
      chk("part_en_cycles", en_cnt[2], 20);
      chk("part_words", acc_cnt[2], 3);
      chk("part_stream", stream[2] & 32'hFFFFF, 32'hFF00F);
      chk("part_rb_count", rbv_cnt[2], 3);
      chk("part_rb0", {24'h0, rb_log[2][0]}, 32'hAB);
      chk("part_rb1", {24'h0, rb_log[2][1]}, 32'hCD);
      chk("part_rb2", {24'h0, rb_log[2][2]}, 32'hE0);
      chk("part_chain", chain[2] & 32'hFFFFF, 32'hFF00F);

      // Reset asserted in the middle of a shift.
      clear_mon(2);
      pulse_start(2);
      feed_word(2, 8'h55, 0);
      @(negedge prog_clk);
      #1;
      prog_reset = 1'b0;
      #1;
      chk1("mrst_clk_en", clk_en[2], 1'b0);
      chk1("mrst_head", head[2], 1'b0);
      chk1("mrst_busy", busy[2], 1'b0);
      chk1("mrst_s_ready", s_ready[2], 1'b0);
      chk1("mrst_rb_valid", rb_valid[2], 1'b0);
      chk("mrst_rb_data", {24'h0, rb_data[2]}, 32'h0);
      @(negedge prog_clk);
      prog_reset = 1'b1;
      d0_done = done_cnt[2];
      d0_rbv  = rbv_cnt[2];
      repeat (10) @(negedge prog_clk);
      chk("mrst_no_done", done_cnt[2], d0_done);
      chk("mrst_no_rb", rbv_cnt[2], d0_rbv);
      chk1("mrst_idle", busy[2], 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
